btn_event_stretcher: RTL and testbench
======================================

// Module: btn_event_stretcher
// PURPOSE
//  Output-side counterpart of the button debouncer. It takes one-cycle, active-low event
//  pulses (idle high) per channel and stretches each into a visible/audible blink train.
//  Each train is N_BLINKS pulses, each ON_CLKS cycles on and OFF_CLKS cycles off.
//  It sits between game logic and the LED/buzzer pins, giving feedback on accepted moves.
// PARAMETERS
//  ON_CLKS     25000  cycles each blink holds the output high (>=1)
//  OFF_CLKS    25000  cycles of low gap after each blink (>=1)
//  N_BLINKS    2      blinks per event (>=1)
//  N_CHANNELS  3      independent channels
// PORTS
//  clk        in   1           system clock, all state on posedge
//  rst        in   1           asynchronous, active-high reset
//  e_debug    in   1           1: bypass, pulses_out = ~evts_in (combinational)
//  evts_in    in   N_CHANNELS  active-low one-cycle event strobes, idle all-ones
//  pulses_out out  N_CHANNELS  active-high stretched outputs
//  busy       out  N_CHANNELS  high while a channel is in ON or OFF state
// BEHAVIOUR
//  - Channels are fully independent. Each channel runs a 3-state FSM: IDLE, ON, OFF.
//  - Each channel keeps a cycle counter of width $clog2(max(ON_CLKS,OFF_CLKS))+1.
//  - Each channel keeps a blink counter of width $clog2(N_BLINKS)+1.
//  - Reset, asynchronous: all FSMs IDLE, counters 0, pulses_out=0, busy=0.
//  - IDLE: evts_in[i]==0 -> ON next cycle, with cyc=0 and blink=0. Otherwise stay IDLE.
//  - ON: pulses_out[i]=1. cyc increments each cycle.
//    At cyc==ON_CLKS-1 -> OFF with cyc=0, so the output is high exactly ON_CLKS cycles.
//  - OFF: pulses_out[i]=0. cyc increments each cycle. At cyc==OFF_CLKS-1:
//    - if blink==N_BLINKS-1 -> IDLE;
//    - else blink++ and go to ON with cyc=0.
//  - Outputs are registered, decoded from state flops.
//    First high cycle of pulses_out is the cycle after evts_in is sampled low (latency 1).
//  - busy[i]=1 in ON and OFF. The trailing OFF gap always completes before IDLE,
//    so back-to-back trains stay visibly separated.
//  - Retrigger: evts_in[i]==0 while in ON or OFF -> restart at ON with cyc=0, blink=0.
//    Retrigger has priority over the terminal-count transition in the same cycle.
//  - evts_in held low for several cycles acts as repeated retriggers.
//    The train starts after the last low cycle.
//  - Simultaneous events on several channels: each starts independently, no arbitration.
//  - e_debug affects only the output mux; FSMs keep running underneath.
//    Deasserting e_debug mid-train shows the FSM state immediately.
//  - Reset asserted mid-train aborts it immediately (asynchronous); outputs go 0 at once.
//  - Counters never wrap: terminal compares bound them.
// STRUCTURE
//  - Shared package: 2-bit state encoding (ST_IDLE=0, ST_ON=1, ST_OFF=2).
//    Encoding 3 is illegal and recovers to IDLE.
//  - Shared package: counter-width helper function.
//  - Sub-module btn_event_stretch_chan: one channel's FSM plus counters, params ON/OFF/N_BLINKS.
//  - Top: generate loop over N_CHANNELS plus the e_debug output mux.
// TESTING  (use ON_CLKS=4, OFF_CLKS=3, N_BLINKS=2, N_CHANNELS=3)
//  - Reset: rst=1 mid-train -> pulses_out=000 and busy=000 in the same cycle.
//    After release the channel stays idle until the next event.
//  - Single event: evts_in=110 for 1 cycle at t0 -> pulses_out[0] high t1..t4, low t5..t7,
//    high t8..t11, low t12..t14. busy[0] low from t15.
//  - Retrigger: second event on ch0 at t6 (during OFF) -> high t7..t10.
//    Full 2-blink train follows; no third blink from the first event.
//  - Simultaneous: evts_in=000 for 1 cycle -> all three outputs toggle identically, cycle-exact.
//  - Priority: event coincident with the last OFF cycle -> returns to ON, not IDLE, blink=0.
//  - Debug: e_debug=1, evts_in=101 -> pulses_out=010 combinationally.
//    Internal busy[1] still asserts and follows the normal train.

Source files
------------

// File: rtl/btn_event_stretcher_pkg.sv
// ============================================================================
// btn_event_stretcher_pkg : shared state encoding and counter sizing
// Rev 1.0
// ============================================================================
`default_nettype none

package btn_event_stretcher_pkg;

  // Encoding 2'b11 is unused and is steered back to idle by the channel FSM.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } stretch_state_e;

  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_event_stretcher_if.sv
// ============================================================================
// btn_event_stretcher_if : event strobes in, stretched pulses and busy out
// Rev 1.0
// ============================================================================
`default_nettype none

interface btn_event_stretcher_if #(
  parameter int N_CHANNELS = 3
);
  logic                  e_debug;
  logic [N_CHANNELS-1:0] evts_in;
  logic [N_CHANNELS-1:0] pulses_out;
  logic [N_CHANNELS-1:0] busy;

  modport master (
    output e_debug,
    output evts_in,
    input  pulses_out,
    input  busy
  );

  modport slave (
    input  e_debug,
    input  evts_in,
    output pulses_out,
    output busy
  );
endinterface

`default_nettype wire

// File: rtl/btn_event_stretch_chan.sv
// ============================================================================
// btn_event_stretch_chan : one channel, active-low strobe -> N-blink train
// Rev 1.0
// ============================================================================
`default_nettype none

module btn_event_stretch_chan
  import btn_event_stretcher_pkg::*;
#(
  parameter int ON_CLKS  = 25000,
  parameter int OFF_CLKS = 25000,
  parameter int N_BLINKS = 2
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic evt_n_i,
  output logic      pulse_o,
  output logic      busy_o
);

  localparam int CYC_W = cnt_width(ON_CLKS, OFF_CLKS);
  localparam int BLK_W = $clog2(N_BLINKS) + 1;

  localparam logic [CYC_W-1:0] C_ON_LAST  = CYC_W'(ON_CLKS - 1);
  localparam logic [CYC_W-1:0] C_OFF_LAST = CYC_W'(OFF_CLKS - 1);
  localparam logic [BLK_W-1:0] C_BLK_LAST = BLK_W'(N_BLINKS - 1);

  stretch_state_e   state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [BLK_W-1:0] blink_q, blink_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      blink_q <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      blink_q <= blink_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    blink_d = blink_q;
    // A strobe restarts the train from any state, ahead of terminal counts.
    if (!evt_n_i) begin
      state_d = ST_ON;
      cyc_d   = '0;
      blink_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cyc_d   = '0;
          blink_d = '0;
        end
        ST_ON: begin
          if (cyc_q == C_ON_LAST) begin
            state_d = ST_OFF;
            cyc_d   = '0;
          end else begin
            cyc_d = cyc_q + CYC_W'(1);
          end
        end
        ST_OFF: begin
          if (cyc_q == C_OFF_LAST) begin
            cyc_d = '0;
            if (blink_q == C_BLK_LAST) begin
              state_d = ST_IDLE;
              blink_d = '0;
            end else begin
              state_d = ST_ON;
              blink_d = blink_q + BLK_W'(1);
            end
          end else begin
            cyc_d = cyc_q + CYC_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cyc_d   = '0;
          blink_d = '0;
        end
      endcase
    end
  end

  assign pulse_o = (state_q == ST_ON);
  assign busy_o  = (state_q == ST_ON) || (state_q == ST_OFF);

endmodule

`default_nettype wire

// File: rtl/btn_event_stretcher.sv
// ============================================================================
// btn_event_stretcher : per-channel blink-train stretcher with debug bypass
// Rev 1.0
// ============================================================================
`default_nettype none

module btn_event_stretcher
  import btn_event_stretcher_pkg::*;
#(
  parameter int ON_CLKS    = 25000,
  parameter int OFF_CLKS   = 25000,
  parameter int N_BLINKS   = 2,
  parameter int N_CHANNELS = 3
) (
  input wire logic              clk,
  input wire logic              rst,
  btn_event_stretcher_if.slave  bus
);

  logic [N_CHANNELS-1:0] w_pulses;
  logic [N_CHANNELS-1:0] w_busy;

  for (genvar g = 0; g < N_CHANNELS; g++) begin : g_chan
    btn_event_stretch_chan #(
      .ON_CLKS  (ON_CLKS),
      .OFF_CLKS (OFF_CLKS),
      .N_BLINKS (N_BLINKS)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .evt_n_i (bus.evts_in[g]),
      .pulse_o (w_pulses[g]),
      .busy_o  (w_busy[g])
    );
  end

  // Bypass only swaps the visible output; channel FSMs keep running.
  assign bus.pulses_out = bus.e_debug ? ~bus.evts_in : w_pulses;
  assign bus.busy       = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_btn_event_stretcher.sv
// ============================================================================
// tb_btn_event_stretcher : scoreboard bench for btn_event_stretcher
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_btn_event_stretcher;

  localparam int ON_CLKS  = 4;
  localparam int OFF_CLKS = 3;
  localparam int N_BLINKS = 2;
  localparam int N_CH     = 3;
  localparam int PERIOD   = ON_CLKS + OFF_CLKS;
  localparam int TRAIN    = N_BLINKS * PERIOD;

  typedef struct packed {
    logic [N_CH-1:0] pulses;
    logic [N_CH-1:0] busy;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   age [N_CH];
  exp_t sb [$];

  btn_event_stretcher_if #(.N_CHANNELS(N_CH)) bus ();

  btn_event_stretcher #(
    .ON_CLKS    (ON_CLKS),
    .OFF_CLKS   (OFF_CLKS),
    .N_BLINKS   (N_BLINKS),
    .N_CHANNELS (N_CH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // age = cycles since the train (re)started; 0 means idle.
  task automatic apply(input logic [N_CH-1:0] ev, input logic dbg);
    exp_t e;
    bus.evts_in = ev;
    bus.e_debug = dbg;
    for (int i = 0; i < N_CH; i++) begin
      e.busy[i]   = (age[i] != 0);
      e.pulses[i] = (age[i] != 0) && (((age[i] - 1) % PERIOD) < ON_CLKS);
    end
    if (dbg) e.pulses = ~ev;
    sb.push_back(e);
    #1;
  endtask

  task automatic advance();
    for (int i = 0; i < N_CH; i++) begin
      if (!bus.evts_in[i]) age[i] = 1;
      else if (age[i] != 0) begin
        age[i]++;
        if (age[i] > TRAIN) age[i] = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back('0);
    e = sb.pop_front();
    checks++;
    if (bus.pulses_out !== e.pulses || bus.busy !== e.busy) begin
      errors++;
      $display("FAIL reset_hold pulses=%b busy=%b expected pulses=%b busy=%b",
               bus.pulses_out, bus.busy, e.pulses, e.busy);
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      apply('1, 1'b0);
      e = sb.pop_front();
      checks++;
      if (bus.pulses_out !== e.pulses || bus.busy !== e.busy) begin
        errors++;
        $display("FAIL reset_idle c%0d pulses=%b busy=%b expected pulses=%b busy=%b",
                 c, bus.pulses_out, bus.busy, e.pulses, e.busy);
      end
      advance();
    end
  endtask

  task automatic test_single();
    exp_t e;
    for (int c = 0; c < 18; c++) begin
      apply((c == 0) ? 3'b110 : 3'b111, 1'b0);
      e = sb.pop_front();
      checks++;
      if (bus.pulses_out !== e.pulses || bus.busy !== e.busy) begin
        errors++;
        $display("FAIL single c%0d pulses=%b busy=%b expected pulses=%b busy=%b",
                 c, bus.pulses_out, bus.busy, e.pulses, e.busy);
      end
      advance();
    end
  endtask

  task automatic test_retrigger();
    exp_t e;
    for (int c = 0; c < 24; c++) begin
      apply((c == 0 || c == 6) ? 3'b110 : 3'b111, 1'b0);
      e = sb.pop_front();
      checks++;
      if (bus.pulses_out !== e.pulses || bus.busy !== e.busy) begin
        errors++;
        $display("FAIL retrigger c%0d pulses=%b busy=%b expected pulses=%b busy=%b",
                 c, bus.pulses_out, bus.busy, e.pulses, e.busy);
      end
      advance();
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    for (int c = 0; c < 17; c++) begin
      apply((c == 0) ? 3'b000 : 3'b111, 1'b0);
      e = sb.pop_front();
      checks++;
      if (bus.pulses_out !== e.pulses || bus.busy !== e.busy) begin
        errors++;
        $display("FAIL simultaneous c%0d pulses=%b busy=%b expected pulses=%b busy=%b",
                 c, bus.pulses_out, bus.busy, e.pulses, e.busy);
      end
      advance();
    end
  endtask

  // Second strobe lands on the final OFF cycle of the first train.
  task automatic test_priority();
    exp_t e;
    for (int c = 0; c < 32; c++) begin
      apply((c == 0 || c == TRAIN) ? 3'b101 : 3'b111, 1'b0);
      e = sb.pop_front();
      checks++;
      if (bus.pulses_out !== e.pulses || bus.busy !== e.busy) begin
        errors++;
        $display("FAIL priority c%0d pulses=%b busy=%b expected pulses=%b busy=%b",
                 c, bus.pulses_out, bus.busy, e.pulses, e.busy);
      end
      advance();
    end
  endtask

  task automatic test_hold_low();
    exp_t e;
    for (int c = 0; c < 20; c++) begin
      apply((c < 3) ? 3'b011 : 3'b111, 1'b0);
      e = sb.pop_front();
      checks++;
      if (bus.pulses_out !== e.pulses || bus.busy !== e.busy) begin
        errors++;
        $display("FAIL hold_low c%0d pulses=%b busy=%b expected pulses=%b busy=%b",
                 c, bus.pulses_out, bus.busy, e.pulses, e.busy);
      end
      advance();
    end
  endtask

  task automatic test_debug();
    exp_t e;
    for (int c = 0; c < 18; c++) begin
      apply((c == 0) ? 3'b101 : 3'b111, (c < 3));
      e = sb.pop_front();
      checks++;
      if (bus.pulses_out !== e.pulses || bus.busy !== e.busy) begin
        errors++;
        $display("FAIL debug c%0d pulses=%b busy=%b expected pulses=%b busy=%b",
                 c, bus.pulses_out, bus.busy, e.pulses, e.busy);
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    for (int c = 0; c < 5; c++) begin
      apply((c == 0) ? 3'b100 : 3'b111, 1'b0);
      e = sb.pop_front();
      checks++;
      if (bus.pulses_out !== e.pulses || bus.busy !== e.busy) begin
        errors++;
        $display("FAIL reset_mid_pre c%0d pulses=%b busy=%b expected pulses=%b busy=%b",
                 c, bus.pulses_out, bus.busy, e.pulses, e.busy);
      end
      advance();
    end
    #2;
    rst = 1'b1;
    for (int i = 0; i < N_CH; i++) age[i] = 0;
    #1;
    sb.push_back('0);
    e = sb.pop_front();
    checks++;
    if (bus.pulses_out !== e.pulses || bus.busy !== e.busy) begin
      errors++;
      $display("FAIL reset_async pulses=%b busy=%b expected pulses=%b busy=%b",
               bus.pulses_out, bus.busy, e.pulses, e.busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 14; c++) begin
      apply((c == 6) ? 3'b110 : 3'b111, 1'b0);
      e = sb.pop_front();
      checks++;
      if (bus.pulses_out !== e.pulses || bus.busy !== e.busy) begin
        errors++;
        $display("FAIL reset_mid_post c%0d pulses=%b busy=%b expected pulses=%b busy=%b",
                 c, bus.pulses_out, bus.busy, e.pulses, e.busy);
      end
      advance();
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.evts_in = '1;
    bus.e_debug = 1'b0;
    for (int i = 0; i < N_CH; i++) age[i] = 0;

    test_reset();
    test_single();
    test_retrigger();
    test_simultaneous();
    test_priority();
    test_hold_low();
    test_debug();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
